// File: rtl/greenhouse_actuator_scheduler.sv
// Power-budgeted scheduler for three greenhouse actuators (fan, irrigation, humidity).
// Each channel enforces minimum on/off times; new grants are shared round-robin, with fan priority during alerts.
module greenhouse_actuator_scheduler #(
    parameter int MIN_ON     = 8,
    parameter int MIN_OFF    = 4,
    parameter int MAX_ACTIVE = 2,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] remote_en,
    input  logic       alert_in,
    output logic [2:0] act_on,
    output logic [2:0] grant_evt,
    output logic [2:0] wait_flag,
    output logic [1:0] active_cnt
);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_ON       = 2'd1,
        ST_ON_FREE  = 2'd2,
        ST_COOLDOWN = 2'd3
    } ch_state_t;

    ch_state_t        state_r     [3];
    ch_state_t        state_nxt_s [3];
    logic [CNT_W-1:0] timer_r     [3];
    logic [CNT_W-1:0] timer_nxt_s [3];
    logic [1:0]       ptr_r;
    logic [1:0]       ptr_nxt_s;
    logic [2:0]       eligible_s;
    logic [2:0]       on_now_s;
    logic [2:0]       leaving_s;
    logic [2:0]       grant_s;
    logic [2:0]       on_nxt_s;
    logic [1:0]       staying_cnt_s;
    logic [1:0]       rr_idx_s;
    logic [1:0]       gidx_s;
    logic             found_s;
    logic             hit_s;
    logic [2:0]       act_on_r;
    logic [2:0]       grant_evt_r;
    logic [2:0]       wait_flag_r;
    logic [1:0]       active_cnt_r;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        popcount3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        logic [2:0] r;
        if (v >= 3'd3) begin
            r = v - 3'd3;
        end else begin
            r = v;
        end
        wrap3 = r[1:0];
    endfunction

    // Classify channels: eligible for a grant, currently on, and releasing at this edge.
    always_comb begin
        eligible_s = 3'b000;
        on_now_s   = 3'b000;
        leaving_s  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            eligible_s[i] = (state_r[i] == ST_OFF) & req[i] & remote_en[i];
            case (state_r[i])
                ST_ON: begin
                    on_now_s[i]  = 1'b1;
                    leaving_s[i] = ~remote_en[i] |
                                   ((timer_r[i] == CNT_W'(MIN_ON - 1)) & ~req[i]);
                end
                ST_ON_FREE: begin
                    on_now_s[i]  = 1'b1;
                    leaving_s[i] = ~remote_en[i] | ~req[i];
                end
                default: begin
                    on_now_s[i]  = 1'b0;
                    leaving_s[i] = 1'b0;
                end
            endcase
        end
        staying_cnt_s = popcount3(on_now_s & ~leaving_s);
    end

    // Single-grant arbiter; releases this edge free budget for a same-edge grant.
    always_comb begin
        grant_s  = 3'b000;
        gidx_s   = 2'd0;
        found_s  = 1'b0;
        rr_idx_s = 2'd0;
        hit_s    = 1'b0;
        if (staying_cnt_s < 2'(MAX_ACTIVE)) begin
            if (alert_in && eligible_s[0]) begin
                grant_s = 3'b001;
                gidx_s  = 2'd0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    rr_idx_s          = wrap3({1'b0, ptr_r} + 3'(k));
                    hit_s             = eligible_s[rr_idx_s] & ~found_s;
                    grant_s[rr_idx_s] = grant_s[rr_idx_s] | hit_s;
                    gidx_s            = hit_s ? rr_idx_s : gidx_s;
                    found_s           = found_s | hit_s;
                end
            end
        end else begin
            grant_s = 3'b000;
        end
        if (grant_s != 3'b000) begin
            ptr_nxt_s = wrap3({1'b0, gidx_s} + 3'd1);
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Per-channel state and timer transitions.
    always_comb begin
        on_nxt_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            state_nxt_s[i] = state_r[i];
            timer_nxt_s[i] = timer_r[i];
            case (state_r[i])
                ST_OFF: begin
                    timer_nxt_s[i] = {CNT_W{1'b0}};
                    if (grant_s[i]) begin
                        state_nxt_s[i] = ST_ON;
                    end else begin
                        state_nxt_s[i] = ST_OFF;
                    end
                end
                ST_ON: begin
                    if (!remote_en[i]) begin
                        state_nxt_s[i] = ST_COOLDOWN;
                        timer_nxt_s[i] = {CNT_W{1'b0}};
                    end else if (timer_r[i] == CNT_W'(MIN_ON - 1)) begin
                        state_nxt_s[i] = req[i] ? ST_ON_FREE : ST_COOLDOWN;
                        timer_nxt_s[i] = {CNT_W{1'b0}};
                    end else begin
                        timer_nxt_s[i] = timer_r[i] + CNT_W'(1);
                    end
                end
                ST_ON_FREE: begin
                    timer_nxt_s[i] = {CNT_W{1'b0}};
                    if (!remote_en[i] || !req[i]) begin
                        state_nxt_s[i] = ST_COOLDOWN;
                    end else begin
                        state_nxt_s[i] = ST_ON_FREE;
                    end
                end
                ST_COOLDOWN: begin
                    if (timer_r[i] == CNT_W'(MIN_OFF - 1)) begin
                        state_nxt_s[i] = ST_OFF;
                        timer_nxt_s[i] = {CNT_W{1'b0}};
                    end else begin
                        timer_nxt_s[i] = timer_r[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s[i] = ST_OFF;
                    timer_nxt_s[i] = {CNT_W{1'b0}};
                end
            endcase
            on_nxt_s[i] = (state_nxt_s[i] == ST_ON) | (state_nxt_s[i] == ST_ON_FREE);
        end
    end

    // State, timers, pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                state_r[i] <= ST_OFF;
                timer_r[i] <= {CNT_W{1'b0}};
            end
            ptr_r        <= 2'd0;
            act_on_r     <= 3'b000;
            grant_evt_r  <= 3'b000;
            wait_flag_r  <= 3'b000;
            active_cnt_r <= 2'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_r[i] <= state_nxt_s[i];
                timer_r[i] <= timer_nxt_s[i];
            end
            ptr_r        <= ptr_nxt_s;
            act_on_r     <= on_nxt_s;
            grant_evt_r  <= grant_s;
            wait_flag_r  <= eligible_s & ~grant_s;
            active_cnt_r <= popcount3(on_nxt_s);
        end
    end

    assign act_on     = act_on_r;
    assign grant_evt  = grant_evt_r;
    assign wait_flag  = wait_flag_r;
    assign active_cnt = active_cnt_r;

endmodule
